fsm_pattern_generator: RTL and testbench
========================================

FSM_PATTERN_GENERATOR -- requirements
Module: fsm_pattern_generator

Interface
REQ-001 Parameter MAX_LEN, default 16: maximum pattern length in symbols.
REQ-002 Parameter B, default 1'b1: encoding of a Bike symbol on d_out; Car is ~B.
REQ-003 clk  input  1  clock; all logic updates on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-006 pattern  input  MAX_LEN  symbols to send; pattern[0] goes first.
REQ-007 len  input  5  number of symbols per repetition; legal range 1..MAX_LEN.
REQ-008 repeat_cnt  input  4  extra repetitions; total repetitions = repeat_cnt+1.
REQ-009 gap  input  4  idle cycles between repetitions.
REQ-010 ready_in  input  1  downstream can accept a symbol this cycle.
REQ-011 d_out  output  1  current symbol (Bike/Car).
REQ-012 valid_out  output  1  d_out holds a valid symbol.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse after the final symbol of the final repetition transfers.
REQ-015 err  output  1  one-cycle pulse when start is rejected for an illegal len.

Function
REQ-016 The block SHALL implement the states IDLE, SEND and GAP, held in a registered state variable; any unused encoding SHALL return to IDLE.
REQ-017 All outputs SHALL be registered.
REQ-018 A transfer SHALL occur on a rising edge where valid_out=1 and ready_in=1.
REQ-019 While valid_out=1 and ready_in=0, d_out and valid_out SHALL hold their values.
REQ-020 IDLE with start=1 and 1<=len<=MAX_LEN: the block SHALL capture pattern, len, repeat_cnt and gap, and enter SEND.
REQ-021 Latency from an accepted start: valid_out=1 with d_out=pattern[0] on the cycle following the start edge.
REQ-022 IDLE with start=1 and len==0 or len>MAX_LEN: err SHALL pulse for one cycle and the state SHALL stay IDLE.
REQ-023 In SEND, each transfer SHALL advance the symbol index by one, so that d_out=pattern[index].
REQ-024 Transfer of symbol index len-1 with repetitions remaining and gap>0: the block SHALL enter GAP with valid_out=0 for exactly gap cycles, then re-enter SEND at index 0.
REQ-025 Transfer of the last symbol with repetitions remaining and gap==0: the block SHALL present index 0 on the next cycle, with no idle cycle.
REQ-026 Transfer of the last symbol of the last repetition: the block SHALL enter IDLE, deassert valid_out, deassert busy and pulse done, all on the following cycle.
REQ-027 ready_in SHALL have no effect in GAP; the gap counter SHALL count clock cycles.
REQ-028 A start during SEND or GAP SHALL be ignored, and the captured inputs SHALL NOT change.
REQ-029 Changes on pattern, len, repeat_cnt or gap after capture SHALL NOT affect a transmission in progress.
REQ-030 A new start in the cycle done is asserted SHALL be accepted (back-to-back operation).

Reset
REQ-031 While reset=1 at a clock edge, the block SHALL take: state=IDLE, index=0, repetition and gap counters=0, d_out=0, valid_out=0, busy=0, done=0, err=0.
REQ-032 Reset SHALL take priority over start and ready_in.
REQ-033 Reset asserted mid-transmission SHALL abort the transmission without a done pulse.

Verification
REQ-034 pattern=16'h000B, len=5, repeat_cnt=0, ready_in=1 -> d_out=1,1,0,1,0 (B B C B C) on 5 consecutive valid cycles, then done pulses once and busy=0.
REQ-035 Same pattern, with ready_in low for 3 cycles during symbol 2 -> d_out=0 with valid_out=1 held for those 3 cycles, then the sequence completes intact.
REQ-036 len=3, pattern=3'b101, repeat_cnt=2, gap=2 -> 1,0,1, then 2 idle cycles, 1,0,1, then 2 idle cycles, 1,0,1, then done; with gap=0 -> 9 contiguous valid cycles.
REQ-037 start with len=0, then start with len=17 -> err pulses once each, busy stays 0 and valid_out stays 0.
REQ-038 reset=1 asserted at symbol 3 of 5 -> all outputs 0 on the next cycle, no done pulse; a subsequent start transmits from pattern[0].
REQ-039 start pulsed mid-transmission with different inputs -> output unaffected; a start on the done cycle begins a new transmission on the next cycle.

Source files
------------

// File: rtl/fsm_pattern_generator_if.sv
//-----------------------------------------------------------------------------
// fsm_pattern_generator_if
//
// Purpose:
//   Bundles the request bus (start plus the transmission parameters) and the
//   symbol stream handshake of the Bike/Car pattern generator into a single
//   interface. clk and reset stay plain ports on the generator itself.
//
// Signals:
//   start       request to begin a transmission
//   pattern     symbols to send, pattern[0] first (MAX_LEN bits)
//   len         symbols per repetition, legal range 1..MAX_LEN
//   repeat_cnt  extra repetitions (total = repeat_cnt + 1)
//   gap         idle cycles between repetitions
//   ready_in    downstream can accept a symbol this cycle
//   d_out       current symbol
//   valid_out   d_out holds a valid symbol
//   busy        generator is not idle
//   done        one-cycle pulse after the final symbol transfers
//   err         one-cycle pulse when a start is rejected for an illegal len
//
// Modports:
//   master  drives the request bus and ready_in, observes the outputs
//   slave   the generator side
//-----------------------------------------------------------------------------
interface fsm_pattern_generator_if #(
    parameter int MAX_LEN = 16
);
    logic               start;
    logic [MAX_LEN-1:0] pattern;
    logic [4:0]         len;
    logic [3:0]         repeat_cnt;
    logic [3:0]         gap;
    logic               ready_in;
    logic               d_out;
    logic               valid_out;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start,
        output pattern,
        output len,
        output repeat_cnt,
        output gap,
        output ready_in,
        input  d_out,
        input  valid_out,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  start,
        input  pattern,
        input  len,
        input  repeat_cnt,
        input  gap,
        input  ready_in,
        output d_out,
        output valid_out,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/fsm_pattern_generator.sv
//-----------------------------------------------------------------------------
// fsm_pattern_generator
//
// Purpose:
//   Sends a captured pattern of Bike/Car symbols over a valid/ready stream.
//   A start in IDLE with a legal length captures pattern, len, repeat_cnt and
//   gap and begins transmitting; the pattern is sent repeat_cnt+1 times with
//   gap idle cycles between repetitions. done pulses once the final symbol
//   has been transferred, err pulses when a start carries an illegal length.
//
// Parameters:
//   MAX_LEN  maximum pattern length in symbols
//   B        encoding of a Bike symbol on d_out (Car is ~B); a '1' bit in
//            pattern is a Bike
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    fsm_pattern_generator_if slave modport (request bus, stream
//          handshake and status pulses)
//
// All outputs are driven straight from registers.
//-----------------------------------------------------------------------------
module fsm_pattern_generator #(
    parameter int   MAX_LEN = 16,
    parameter logic B       = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    fsm_pattern_generator_if.slave    bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int unsigned MAX_LEN_U = MAX_LEN;

    // Registered state and captured transmission parameters
    logic [1:0]         state_q,  state_d;
    logic [MAX_LEN-1:0] pat_q,    pat_d;
    logic [4:0]         len_q,    len_d;
    logic [3:0]         gap_q,    gap_d;
    logic [4:0]         idx_q,    idx_d;
    logic [3:0]         rep_q,    rep_d;
    logic [3:0]         gcnt_q,   gcnt_d;

    // Registered outputs
    logic               d_out_q,  d_out_d;
    logic               valid_q,  valid_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic               err_q,    err_d;

    // Helpers
    logic               len_ok;
    logic               xfer;
    logic               last_sym;
    logic [4:0]         idx_inc;
    logic [MAX_LEN-1:0] next_sel;
    logic               sym_next;

    function automatic logic encode(input logic bike);
        return bike ? B : ~B;
    endfunction

    assign len_ok   = (bus.len != 5'd0) && (32'(bus.len) <= MAX_LEN_U);
    assign xfer     = valid_q && bus.ready_in;
    assign last_sym = (idx_q == (len_q - 5'd1));
    assign idx_inc  = idx_q + 5'd1;

    // One-hot select of the symbol after the current one; avoids a variable
    // part-select whose index width would not match the pattern width.
    assign next_sel = {{(MAX_LEN-1){1'b0}}, 1'b1} << idx_inc;
    assign sym_next = |(pat_q & next_sel);

    // Next-state and next-output logic. Every register holds by default;
    // done and err are pulses and clear unless explicitly raised.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        gcnt_d  = gcnt_q;
        d_out_d = d_out_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (bus.start) begin
                    if (len_ok) begin
                        pat_d   = bus.pattern;
                        len_d   = bus.len;
                        rep_d   = bus.repeat_cnt;
                        gap_d   = bus.gap;
                        idx_d   = 5'd0;
                        gcnt_d  = 4'd0;
                        d_out_d = encode(bus.pattern[0]);
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        state_d = ST_SEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_SEND: begin
                // Without a transfer everything holds, which keeps d_out and
                // valid_out stable while downstream stalls.
                if (xfer) begin
                    if (!last_sym) begin
                        idx_d   = idx_inc;
                        d_out_d = encode(sym_next);
                    end else if (rep_q != 4'd0) begin
                        rep_d = rep_q - 4'd1;
                        idx_d = 5'd0;
                        if (gap_q != 4'd0) begin
                            state_d = ST_GAP;
                            gcnt_d  = gap_q;
                            valid_d = 1'b0;
                        end else begin
                            d_out_d = encode(pat_q[0]);
                        end
                    end else begin
                        state_d = ST_IDLE;
                        idx_d   = 5'd0;
                        d_out_d = 1'b0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_GAP: begin
                // gcnt holds the idle cycles still to be shown including the
                // current one, so the last gap cycle is the one with gcnt==1.
                if (gcnt_q <= 4'd1) begin
                    state_d = ST_SEND;
                    gcnt_d  = 4'd0;
                    d_out_d = encode(pat_q[0]);
                    valid_d = 1'b1;
                end else begin
                    gcnt_d = gcnt_q - 4'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = 5'd0;
                rep_d   = 4'd0;
                gcnt_d  = 4'd0;
                d_out_d = 1'b0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset wins over
    // start and ready_in and aborts a transmission without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= 5'd0;
            gap_q   <= 4'd0;
            idx_q   <= 5'd0;
            rep_q   <= 4'd0;
            gcnt_q  <= 4'd0;
            d_out_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            gcnt_q  <= gcnt_d;
            d_out_q <= d_out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.d_out     = d_out_q;
    assign bus.valid_out = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_fsm_pattern_generator.sv
//-----------------------------------------------------------------------------
// tb_fsm_pattern_generator
//
// Purpose:
//   Self-checking bench for fsm_pattern_generator. A queue-based model turns
//   each accepted start into the list of symbols that must appear on the
//   stream, and tracks gaps, done and err pulses; one process compares the
//   DUT against it every cycle. Directed tests additionally pin the model
//   with hand-computed symbol sequences and transfer timings.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fsm_pattern_generator;

    localparam int   MAX_LEN = 16;
    localparam logic B_ENC   = 1'b1;

    logic clk;
    logic reset;

    int cyc       = 0;
    int start_cyc = 0;

    int n_compared   = 0;
    int n_mismatched = 0;

    bit model_on = 1'b0;

    // Transfer log (symbol and cycle offset from the last applied start)
    int xfer_sym[$];
    int xfer_off[$];
    int done_cnt = 0;
    int err_cnt  = 0;

    // Model state
    bit m_active   = 1'b0;
    int m_syms[$];
    int m_len      = 0;
    int m_pos      = 0;
    int m_gap      = 0;
    int m_gap_left = 0;
    bit exp_reset  = 1'b1;
    bit exp_done   = 1'b0;
    bit exp_err    = 1'b0;

    int es[$];
    int eo[$];

    fsm_pattern_generator_if #(.MAX_LEN(MAX_LEN)) bus ();

    fsm_pattern_generator #(
        .MAX_LEN(MAX_LEN),
        .B      (B_ENC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic encode(input int bike);
        return (bike != 0) ? B_ENC : ~B_ENC;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Per-cycle compare against the model, then advance the model using the
    // inputs that the coming rising edge will sample.
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                if (exp_reset) begin
                    checkOutput("rst_d_out", bus.d_out, 0);
                    checkOutput("rst_valid", bus.valid_out, 0);
                    checkOutput("rst_busy", bus.busy, 0);
                    checkOutput("rst_done", bus.done, 0);
                    checkOutput("rst_err", bus.err, 0);
                end else begin
                    checkOutput("m_done", bus.done, exp_done);
                    checkOutput("m_err", bus.err, exp_err);
                    if (m_active) begin
                        checkOutput("m_busy", bus.busy, 1);
                        checkOutput("m_valid", bus.valid_out, (m_gap_left == 0) ? 1 : 0);
                        if (m_gap_left == 0)
                            checkOutput("m_d_out", bus.d_out, encode(m_syms[0]));
                    end else begin
                        checkOutput("m_busy_idle", bus.busy, 0);
                        checkOutput("m_valid_idle", bus.valid_out, 0);
                    end
                end

                if (bus.done === 1'b1) done_cnt++;
                if (bus.err === 1'b1) err_cnt++;
                if (bus.valid_out === 1'b1 && bus.ready_in && !reset) begin
                    xfer_sym.push_back(int'(bus.d_out));
                    xfer_off.push_back(cyc - start_cyc);
                end

                exp_done  = 1'b0;
                exp_err   = 1'b0;
                exp_reset = 1'b0;
                if (reset) begin
                    m_active   = 1'b0;
                    m_syms.delete();
                    m_gap_left = 0;
                    m_pos      = 0;
                    exp_reset  = 1'b1;
                end else if (m_active) begin
                    if (m_gap_left > 0) begin
                        m_gap_left--;
                    end else if (bus.ready_in) begin
                        void'(m_syms.pop_front());
                        m_pos++;
                        if (m_pos == m_len) begin
                            m_pos = 0;
                            if (m_syms.size() == 0) begin
                                m_active = 1'b0;
                                exp_done = 1'b1;
                            end else begin
                                m_gap_left = m_gap;
                            end
                        end
                    end
                end else if (bus.start) begin
                    if (int'(bus.len) >= 1 && int'(bus.len) <= MAX_LEN) begin
                        logic [MAX_LEN-1:0] pv;
                        pv = bus.pattern;
                        m_syms.delete();
                        for (int r = 0; r <= int'(bus.repeat_cnt); r++)
                            for (int i = 0; i < int'(bus.len); i++)
                                m_syms.push_back(int'((pv >> i) & 16'd1));
                        m_len      = int'(bus.len);
                        m_gap      = int'(bus.gap);
                        m_pos      = 0;
                        m_gap_left = 0;
                        m_active   = 1'b1;
                    end else begin
                        exp_err = 1'b1;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] p, input logic [4:0] l,
                                 input logic [3:0] r, input logic [3:0] g);
        @(posedge clk); #1;
        bus.pattern    = p;
        bus.len        = l;
        bus.repeat_cnt = r;
        bus.gap        = g;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        start_cyc = cyc;
        bus.start = 1'b0;
    endtask

    task automatic clearLog();
        xfer_sym.delete();
        xfer_off.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic waitDone(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        checkOutput("done_reached", seen, 1);
        @(negedge clk); #1;
    endtask

    task automatic checkLog(input string name, input int exp_s[$], input int exp_o[$]);
        checkOutput({name, "_count"}, xfer_sym.size(), exp_s.size());
        for (int i = 0; i < exp_s.size(); i++) begin
            if (i < xfer_sym.size()) begin
                checkOutput({name, "_sym"}, xfer_sym[i], exp_s[i]);
                checkOutput({name, "_off"}, xfer_off[i], exp_o[i]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.pattern    = '0;
        bus.len        = 5'd0;
        bus.repeat_cnt = 4'd0;
        bus.gap        = 4'd0;
        bus.ready_in   = 1'b1;

        // Reset state
        @(posedge clk); #1;
        model_on = 1'b1;
        checkOutput("reset_d_out", bus.d_out, 0);
        checkOutput("reset_valid", bus.valid_out, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_err", bus.err, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single repetition, always ready: B B C B C
        clearLog();
        applyStimulus(16'h000B, 5'd5, 4'd0, 4'd0);
        checkOutput("t1_first_valid", bus.valid_out, 1);
        checkOutput("t1_first_sym", bus.d_out, 1);
        waitDone(100);
        es = '{1, 1, 0, 1, 0};
        eo = '{0, 1, 2, 3, 4};
        checkLog("t1", es, eo);
        checkOutput("t1_done_cnt", done_cnt, 1);
        checkOutput("t1_busy_after", bus.busy, 0);

        // Downstream stall for 3 cycles on symbol 2
        clearLog();
        applyStimulus(16'h000B, 5'd5, 4'd0, 4'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.ready_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t2_hold_valid", bus.valid_out, 1);
        checkOutput("t2_hold_sym", bus.d_out, 0);
        @(posedge clk); #1;
        bus.ready_in = 1'b1;
        waitDone(100);
        es = '{1, 1, 0, 1, 0};
        eo = '{0, 1, 5, 6, 7};
        checkLog("t2", es, eo);
        checkOutput("t2_done_cnt", done_cnt, 1);

        // Three repetitions of 1,0,1 with a 2-cycle gap
        clearLog();
        applyStimulus(16'h0005, 5'd3, 4'd2, 4'd2);
        waitDone(100);
        es = '{1, 0, 1, 1, 0, 1, 1, 0, 1};
        eo = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        checkLog("t3", es, eo);
        checkOutput("t3_done_cnt", done_cnt, 1);

        // Same without gap: nine contiguous symbols
        clearLog();
        applyStimulus(16'h0005, 5'd3, 4'd2, 4'd0);
        waitDone(100);
        es = '{1, 0, 1, 1, 0, 1, 1, 0, 1};
        eo = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
        checkLog("t4", es, eo);
        checkOutput("t4_done_cnt", done_cnt, 1);

        // Illegal lengths 0 and 17
        clearLog();
        applyStimulus(16'h000B, 5'd0, 4'd0, 4'd0);
        checkOutput("t5_err_len0", bus.err, 1);
        checkOutput("t5_busy_len0", bus.busy, 0);
        applyStimulus(16'h000B, 5'd17, 4'd0, 4'd0);
        checkOutput("t5_err_len17", bus.err, 1);
        checkOutput("t5_valid_len17", bus.valid_out, 0);
        @(posedge clk); #1;
        checkOutput("t5_err_cleared", bus.err, 0);
        checkOutput("t5_err_cnt", err_cnt, 2);
        checkOutput("t5_no_xfer", xfer_sym.size(), 0);

        // Reset while symbol 3 is presented, then a clean restart
        clearLog();
        applyStimulus(16'h000B, 5'd5, 4'd0, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("t6_abort_valid", bus.valid_out, 0);
        checkOutput("t6_abort_busy", bus.busy, 0);
        checkOutput("t6_abort_d_out", bus.d_out, 0);
        checkOutput("t6_abort_done", bus.done, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t6_no_done", done_cnt, 0);
        es = '{1, 1, 0};
        eo = '{0, 1, 2};
        checkLog("t6a", es, eo);
        clearLog();
        applyStimulus(16'h000B, 5'd5, 4'd0, 4'd0);
        waitDone(100);
        es = '{1, 1, 0, 1, 0};
        eo = '{0, 1, 2, 3, 4};
        checkLog("t6b", es, eo);

        // Ignored mid-run start, input changes after capture, and a
        // back-to-back start in the done cycle
        clearLog();
        applyStimulus(16'h000B, 5'd5, 4'd0, 4'd0);
        @(posedge clk); #1;
        bus.pattern    = 16'hFFFF;
        bus.len        = 5'd2;
        bus.repeat_cnt = 4'd3;
        bus.gap        = 4'd1;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.pattern = 16'h0000;
        bus.len     = 5'd9;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t7_done_cycle", bus.done, 1);
        bus.pattern    = 16'h0006;
        bus.len        = 5'd3;
        bus.repeat_cnt = 4'd1;
        bus.gap        = 4'd1;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checkOutput("t7_b2b_valid", bus.valid_out, 1);
        checkOutput("t7_b2b_busy", bus.busy, 1);
        checkOutput("t7_b2b_sym", bus.d_out, 0);
        waitDone(100);
        es = '{1, 1, 0, 1, 0, 0, 1, 1, 0, 1, 1};
        eo = '{0, 1, 2, 3, 4, 6, 7, 8, 10, 11, 12};
        checkLog("t7", es, eo);
        checkOutput("t7_done_cnt", done_cnt, 2);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
